// File: rtl/dac_comp_sweep_ctrl_if.sv
// Handshake and data bundle between the sweep controller, the DAC step counters and the comparators.
// master drives start/config/comparator outputs; slave is the controller.
interface dac_comp_sweep_ctrl_if;
  logic       start;
  logic       dir;
  logic [1:0] variant;
  logic [7:0] max_steps;
  logic [3:0] settle;
  logic [2:0] voutp;
  logic [2:0] voutm;

  logic       cnt0_clk;
  logic       cnt1_clk;
  logic       en0;
  logic       en1;
  logic       sel;
  logic       dac_rstn;
  logic       comp_clk;
  logic       busy;
  logic       done;
  logic       found;
  logic [7:0] trip_code;
  logic       err;

  modport master (
    output start, dir, variant, max_steps, settle, voutp, voutm,
    input  cnt0_clk, cnt1_clk, en0, en1, sel, dac_rstn, comp_clk, busy, done, found,
           trip_code, err
  );

  modport slave (
    input  start, dir, variant, max_steps, settle, voutp, voutm,
    output cnt0_clk, cnt1_clk, en0, en1, sel, dac_rstn, comp_clk, busy, done, found,
           trip_code, err
  );
endinterface

// File: rtl/dac_comp_sweep_ctrl.sv
// DAC code sweep controller: steps a DAC counter, strobes a comparator and reports the trip code.
// Optional INVALID_RETRY_EN: detect VOUTP==VOUTM as invalid, retry the strobe, flag ERR.
module dac_comp_sweep_ctrl (
  input  logic                        clk,
  input  logic                        rst,
  dac_comp_sweep_ctrl_if.slave        sif
);

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StSettle,
    StStrobe,
    StSample,
    StStep,
    StFinish
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] variant_q, variant_d;
  logic [7:0] max_q, max_d;
  logic [3:0] settle_q, settle_d;
  logic [3:0] settle_cnt_q, settle_cnt_d;
  logic       clr_cnt_q, clr_cnt_d;
  logic [7:0] step_cnt_q, step_cnt_d;
  logic       ref_pol_q, ref_pol_d;
`ifdef INVALID_RETRY_EN
  logic [1:0] retry_q, retry_d;
`endif

  // Registered outputs
  logic       cnt0_clk_q, cnt0_clk_d;
  logic       cnt1_clk_q, cnt1_clk_d;
  logic       en0_q, en0_d;
  logic       en1_q, en1_d;
  logic       sel_q, sel_d;
  logic       dac_rstn_q, dac_rstn_d;
  logic       comp_clk_q, comp_clk_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       found_q, found_d;
  logic [7:0] trip_q, trip_d;
  logic       err_q, err_d;

  logic [1:0] vidx;
  logic       sample;
  logic       valid;
  state_e     after_step;

  always_comb begin
    vidx = 2'd0;
    if (variant_q == 2'd1) vidx = 2'd1;
    else if (variant_q == 2'd2) vidx = 2'd2;
    sample = sif.voutp[vidx];
`ifdef INVALID_RETRY_EN
    valid = (sif.voutp[vidx] != sif.voutm[vidx]);
`else
    valid = 1'b1;
`endif
  end

  always_comb begin
    state_d      = state_q;
    variant_d    = variant_q;
    max_d        = max_q;
    settle_d     = settle_q;
    settle_cnt_d = settle_cnt_q;
    clr_cnt_d    = clr_cnt_q;
    step_cnt_d   = step_cnt_q;
    ref_pol_d    = ref_pol_q;
`ifdef INVALID_RETRY_EN
    retry_d      = retry_q;
`endif
    sel_d        = sel_q;
    found_d      = found_q;
    trip_d       = trip_q;
    err_d        = err_q;
    // Zero settle time skips the SETTLE state entirely
    after_step   = (settle_q == 4'd0) ? StStrobe : StSettle;

    case (state_q)
      StIdle: begin
        if (sif.start) begin
          sel_d      = sif.dir;
          variant_d  = sif.variant;
          max_d      = sif.max_steps;
          settle_d   = sif.settle;
          step_cnt_d = 8'd0;
          clr_cnt_d  = 1'b0;
          found_d    = 1'b0;
          err_d      = 1'b0;
          trip_d     = 8'd0;
`ifdef INVALID_RETRY_EN
          retry_d    = 2'd0;
`endif
          state_d    = StClear;
        end
      end
      StClear: begin
        if (clr_cnt_q) begin
          settle_cnt_d = 4'd0;
          state_d      = after_step;
        end else begin
          clr_cnt_d = 1'b1;
        end
      end
      StSettle: begin
        if (settle_cnt_q == settle_q - 4'd1) state_d = StStrobe;
        else settle_cnt_d = settle_cnt_q + 4'd1;
      end
      StStrobe: state_d = StSample;
      StSample: begin
        if (!valid) begin
`ifdef INVALID_RETRY_EN
          if (retry_q == 2'd3) begin
            err_d   = 1'b1;
            found_d = 1'b0;
            trip_d  = step_cnt_q;
            state_d = StFinish;
          end else begin
            retry_d = retry_q + 2'd1;
            state_d = StStrobe;
          end
`endif
        end else begin
`ifdef INVALID_RETRY_EN
          retry_d = 2'd0;
`endif
          if (step_cnt_q == 8'd0) ref_pol_d = sample;
          if ((step_cnt_q != 8'd0) && (sample != ref_pol_q)) begin
            found_d = 1'b1;
            trip_d  = step_cnt_q;
            state_d = StFinish;
          end else if (step_cnt_q == max_q) begin
            found_d = 1'b0;
            trip_d  = max_q;
            state_d = StFinish;
          end else begin
            state_d = StStep;
          end
        end
      end
      StStep: begin
        step_cnt_d   = step_cnt_q + 8'd1;
        settle_cnt_d = 4'd0;
        state_d      = after_step;
      end
      StFinish: begin
        sel_d   = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Outputs are decoded from the next state so they line up with the state register
    busy_d     = (state_d != StIdle);
    done_d     = (state_d == StFinish);
    comp_clk_d = (state_d == StStrobe);
    dac_rstn_d = (state_d != StClear);
    cnt0_clk_d = (state_d == StStep) && !sel_d;
    cnt1_clk_d = (state_d == StStep) && sel_d;
    en0_d      = busy_d && !sel_d;
    en1_d      = busy_d && sel_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      variant_q    <= 2'd0;
      max_q        <= 8'd0;
      settle_q     <= 4'd0;
      settle_cnt_q <= 4'd0;
      clr_cnt_q    <= 1'b0;
      step_cnt_q   <= 8'd0;
      ref_pol_q    <= 1'b0;
`ifdef INVALID_RETRY_EN
      retry_q      <= 2'd0;
`endif
      cnt0_clk_q   <= 1'b0;
      cnt1_clk_q   <= 1'b0;
      en0_q        <= 1'b0;
      en1_q        <= 1'b0;
      sel_q        <= 1'b0;
      dac_rstn_q   <= 1'b1;
      comp_clk_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      found_q      <= 1'b0;
      trip_q       <= 8'd0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      variant_q    <= variant_d;
      max_q        <= max_d;
      settle_q     <= settle_d;
      settle_cnt_q <= settle_cnt_d;
      clr_cnt_q    <= clr_cnt_d;
      step_cnt_q   <= step_cnt_d;
      ref_pol_q    <= ref_pol_d;
`ifdef INVALID_RETRY_EN
      retry_q      <= retry_d;
`endif
      cnt0_clk_q   <= cnt0_clk_d;
      cnt1_clk_q   <= cnt1_clk_d;
      en0_q        <= en0_d;
      en1_q        <= en1_d;
      sel_q        <= sel_d;
      dac_rstn_q   <= dac_rstn_d;
      comp_clk_q   <= comp_clk_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      found_q      <= found_d;
      trip_q       <= trip_d;
      err_q        <= err_d;
    end
  end

  assign sif.cnt0_clk  = cnt0_clk_q;
  assign sif.cnt1_clk  = cnt1_clk_q;
  assign sif.en0       = en0_q;
  assign sif.en1       = en1_q;
  assign sif.sel       = sel_q;
  assign sif.dac_rstn  = dac_rstn_q;
  assign sif.comp_clk  = comp_clk_q;
  assign sif.busy      = busy_q;
  assign sif.done      = done_q;
  assign sif.found     = found_q;
  assign sif.trip_code = trip_q;
  assign sif.err       = err_q;

endmodule
